// File: rtl/twiddle_table_loader_pkg.sv
// Shared twiddle symmetry definitions: octant -> (swap, sign) map and mirror-address rule.
// The twiddle-convert stage imports the same package so both ends agree on one symmetry.
package twiddle_table_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic swap;
        logic neg_re;
        logic neg_im;
    } sym_map_t;

    // Expected (re, im) from first-octant entry (r, i):
    // 1:(-i,-r) 2:(i,-r) 3:(-r,i) 4:(-r,-i) 5:(i,r); other octants pass through.
    function automatic sym_map_t oct_map(input logic [2:0] oct);
        sym_map_t m;
        case (oct)
            3'd1:    m = '{swap: 1'b1, neg_re: 1'b1, neg_im: 1'b1};
            3'd2:    m = '{swap: 1'b1, neg_re: 1'b0, neg_im: 1'b1};
            3'd3:    m = '{swap: 1'b0, neg_re: 1'b1, neg_im: 1'b0};
            3'd4:    m = '{swap: 1'b0, neg_re: 1'b1, neg_im: 1'b1};
            3'd5:    m = '{swap: 1'b1, neg_re: 1'b0, neg_im: 1'b0};
            default: m = '{swap: 1'b0, neg_re: 1'b0, neg_im: 1'b0};
        endcase
        return m;
    endfunction

    // Odd octants read the table mirrored (address -low mod T).
    function automatic logic oct_mirrored(input logic [2:0] oct);
        return oct[0];
    endfunction

    function automatic logic oct_checked(input logic [2:0] oct);
        return (oct >= 3'd1) && (oct <= 3'd5);
    endfunction

endpackage

// File: rtl/twiddle_table_loader_symmetry.sv
// Combinational octant symmetry: first-octant entry (r, i) -> expected twiddle in octant oct.
module twiddle_symmetry
    import twiddle_table_loader_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       oct,
    input  logic [WIDTH-1:0] tab_r,
    input  logic [WIDTH-1:0] tab_i,
    output logic [WIDTH-1:0] exp_r,
    output logic [WIDTH-1:0] exp_i
);

    sym_map_t         map_s;
    logic [WIDTH-1:0] sel_r;
    logic [WIDTH-1:0] sel_i;

    assign map_s = oct_map(oct);
    assign sel_r = map_s.swap ? tab_i : tab_r;
    assign sel_i = map_s.swap ? tab_r : tab_i;
    // Negation wraps at WIDTH bits, matching the converter's arithmetic.
    assign exp_r = map_s.neg_re ? (WIDTH'(0) - sel_r) : sel_r;
    assign exp_i = map_s.neg_im ? (WIDTH'(0) - sel_i) : sel_i;

endmodule

// File: rtl/twiddle_table_loader.sv
// Loads the first octant of a streamed N-point twiddle table, checks octants 1..5 against
// symmetry, and serves the stored octant through a registered read port.
module twiddle_table_loader
    import twiddle_table_loader_pkg::*;
#(
    parameter int LOG_N = 6,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data_r,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             busy,
    output logic             done,
    output logic             table_valid,
    output logic             err,
    output logic [LOG_N-1:0] err_count,
    input  logic [LOG_N-4:0] rd_addr,
    output logic [WIDTH-1:0] rd_data_r,
    output logic [WIDTH-1:0] rd_data_i
);

    localparam int TAW = LOG_N - 3;
    localparam int T   = 1 << TAW;

    state_e             state_q, state_d;
    logic [LOG_N-1:0]   k_q, k_d;
    logic               last_q, last_d;
    logic               chk_en_q, chk_en_d;
    logic [2:0]         chk_oct_q, chk_oct_d;
    logic [WIDTH-1:0]   chk_r_q, chk_r_d;
    logic [WIDTH-1:0]   chk_i_q, chk_i_d;
    logic               err_q, err_d;
    logic [LOG_N-1:0]   err_count_q, err_count_d;
    logic               table_valid_q, table_valid_d;

    logic [2*WIDTH-1:0] table_mem [T];
    logic [2*WIDTH-1:0] chk_word_q;
    logic [2*WIDTH-1:0] rd_word_q;

    logic               accept;
    logic [2:0]         oct;
    logic [TAW-1:0]     low;
    logic [TAW-1:0]     mirror_addr;
    logic               wr_en;
    logic [WIDTH-1:0]   exp_r;
    logic [WIDTH-1:0]   exp_i;
    logic               mismatch;

    // in_ready drops while the final beat drains so the wrapped k cannot take a stray beat.
    assign in_ready    = (state_q == ST_LOAD) && !last_q;
    assign busy        = (state_q == ST_LOAD);
    assign done        = (state_q == ST_DONE);
    assign table_valid = table_valid_q;
    assign err         = err_q;
    assign err_count   = err_count_q;
    assign {rd_data_r, rd_data_i} = rd_word_q;

    assign accept      = in_valid && in_ready;
    assign oct         = k_q[LOG_N-1 -: 3];
    assign low         = k_q[TAW-1:0];
    assign mirror_addr = oct_mirrored(oct) ? (TAW'(0) - low) : low;
    assign wr_en       = accept && (oct == 3'd0);

    twiddle_symmetry #(.WIDTH(WIDTH)) u_symmetry (
        .oct   (chk_oct_q),
        .tab_r (chk_word_q[2*WIDTH-1:WIDTH]),
        .tab_i (chk_word_q[WIDTH-1:0]),
        .exp_r (exp_r),
        .exp_i (exp_i)
    );

    assign mismatch = chk_en_q && ((exp_r != chk_r_q) || (exp_i != chk_i_q));

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        last_d        = 1'b0;
        chk_en_d      = 1'b0;
        chk_oct_d     = chk_oct_q;
        chk_r_d       = chk_r_q;
        chk_i_d       = chk_i_q;
        err_d         = err_q;
        err_count_d   = err_count_q;
        table_valid_d = table_valid_q;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    k_d       = k_q + LOG_N'(1);
                    chk_en_d  = oct_checked(oct) && (low != '0);
                    chk_oct_d = oct;
                    chk_r_d   = in_data_r;
                    chk_i_d   = in_data_i;
                    last_d    = &k_q;
                end
                if (last_q) begin
                    state_d       = ST_DONE;
                    table_valid_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = state_q;
        endcase

        if (mismatch) begin
            err_d = 1'b1;
            if (err_count_q != '1) begin
                err_count_d = err_count_q + LOG_N'(1);
            end
        end

        // A restart wins over everything, including a beat in flight.
        if (load_start) begin
            state_d       = ST_LOAD;
            k_d           = '0;
            last_d        = 1'b0;
            chk_en_d      = 1'b0;
            err_d         = 1'b0;
            err_count_d   = '0;
            table_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            k_q           <= '0;
            last_q        <= 1'b0;
            chk_en_q      <= 1'b0;
            chk_oct_q     <= '0;
            chk_r_q       <= '0;
            chk_i_q       <= '0;
            err_q         <= 1'b0;
            err_count_q   <= '0;
            table_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            last_q        <= last_d;
            chk_en_q      <= chk_en_d;
            chk_oct_q     <= chk_oct_d;
            chk_r_q       <= chk_r_d;
            chk_i_q       <= chk_i_d;
            err_q         <= err_d;
            err_count_q   <= err_count_d;
            table_valid_q <= table_valid_d;
        end
    end

    // Table RAM: one write port plus the check read port; contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            table_mem[low] <= {in_data_r, in_data_i};
        end
        chk_word_q <= table_mem[mirror_addr];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_word_q <= '0;
        end else begin
            rd_word_q <= table_mem[rd_addr];
        end
    end

endmodule
